sram_responder: RTL and testbench

- Word-organised memory responder for the CPU data/instruction request interface (r_v, w_v, adr, data, strobe in; resp, resp_valid out).
- Accepts one request per cycle with no backpressure and applies byte-strobed writes.
- Returns read data, or a write acknowledge, after a fixed, parameterised latency.
- Intended as the configurable-latency replacement for the single-cycle memory model in CPU benches, so that CPU stall and ordering logic gets exercised.

---
 rtl/sram_responder_pkg.sv | 32 +++
 rtl/sram_responder_if.sv | 38 +++
 rtl/sram_responder_latency_pipe.sv | 38 +++
 rtl/sram_responder.sv | 103 ++++++++++
 tb/tb_sram_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_responder_pkg.sv
// Shared types and helpers for the sram_responder memory model.
// Optional error reporting is enabled with the SRAM_RESPONDER_ERR_EN macro.
package sram_responder_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned MAX_LATENCY = 8;

    // One response pipeline entry; payload is 0 for write acks and idle stages
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] payload;
    } resp_stage_t;

    // Replace the byte lanes of old_word selected by strobe with new_word
    function automatic logic [DATA_W-1:0] strobe_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strobe
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Request/response bus between a CPU port (master) and sram_responder (slave).
// With SRAM_RESPONDER_ERR_EN defined the bus also carries resp_err/err_seen.
interface sram_responder_if;
    import sram_responder_pkg::*;

    logic              r_v;
    logic              w_v;
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] resp;
    logic              resp_valid;
`ifdef SRAM_RESPONDER_ERR_EN
    logic              resp_err;
    logic              err_seen;

    modport master (
        output r_v, w_v, adr, data, strobe,
        input  resp, resp_valid, resp_err, err_seen
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe,
        output resp, resp_valid, resp_err, err_seen
    );
`else
    modport master (
        output r_v, w_v, adr, data, strobe,
        input  resp, resp_valid
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe,
        output resp, resp_valid
    );
`endif

endinterface

// File: rtl/sram_responder_latency_pipe.sv
// Fixed-depth shift register of response entries with synchronous flush.
// Every stage is cleared on reset so nothing in flight survives it.
module sram_responder_latency_pipe
    import sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  resp_stage_t i_stage,
    output resp_stage_t o_stage
);

    resp_stage_t [DEPTH-1:0] r_stages;

    if (DEPTH == 1) begin : g_single
        // Single stage: load directly from the request side
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_stages <= '0;
            end else begin
                r_stages <= i_stage;
            end
        end
    end else begin : g_multi
        // Shift toward the output end, new entry enters at stage 0
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_stages <= '0;
            end else begin
                r_stages <= {r_stages[DEPTH-2:0], i_stage};
            end
        end
    end

    assign o_stage = r_stages[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Word-organised memory responder with byte-strobed writes and a fixed,
// parameterised response latency. Accepts one request per cycle, never stalls.
// Optional feature: SRAM_RESPONDER_ERR_EN adds resp_err and sticky err_seen.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0002_0000,
    parameter int unsigned SIZE         = 2048,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LATENCY      = 1
) (
    input logic            clk,
    input logic            rst_n,
    sram_responder_if.slave io_bus
);

    localparam int unsigned IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned ADR_EXT_W = DATA_W + 1;

    if (XLEN != DATA_W) begin : g_bad_xlen
        $error("sram_responder: only XLEN=32 is supported");
    end

    if ((LATENCY == 0) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
        $error("sram_responder: LATENCY must be in 1..%0d", MAX_LATENCY);
    end

    logic [DATA_W-1:0]    mem [SIZE];

    logic [ADR_EXT_W-1:0] w_adr_ext;
    logic [ADR_EXT_W-1:0] w_base_ext;
    logic [ADR_EXT_W-1:0] w_limit_ext;
    logic [ADR_EXT_W-1:0] w_offset;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_req;
    logic                 w_wr_en;
    logic [DATA_W-1:0]    w_rd_word;
    resp_stage_t          w_stage_in;
    resp_stage_t          w_out;

    // Address decode in 33-bit arithmetic so the window end never wraps
    assign w_adr_ext   = {1'b0, io_bus.adr};
    assign w_base_ext  = {1'b0, BASE_ADDRESS};
    assign w_limit_ext = w_base_ext + ADR_EXT_W'(4 * SIZE);
    assign w_in_range  = (w_adr_ext >= w_base_ext) && (w_adr_ext < w_limit_ext);
    assign w_offset    = w_adr_ext - w_base_ext;
    assign w_idx       = IDX_W'(w_offset >> 2);

    // A request is anything valid outside reset; w_v wins over r_v
    assign w_req     = rst_n && (io_bus.r_v || io_bus.w_v);
    assign w_wr_en   = rst_n && io_bus.w_v && w_in_range;
    assign w_rd_word = w_in_range ? mem[w_idx] : '0;

    // Byte-strobed array write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_idx] <= strobe_merge(mem[w_idx], io_bus.data, io_bus.strobe);
        end
    end

    // Build the response entry for this cycle's request (all-zero when idle)
    always_comb begin
        w_stage_in = '0;
        if (w_req) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.err   = !w_in_range || (io_bus.w_v && (io_bus.strobe == '0));
            w_stage_in.payload = io_bus.w_v ? '0 : w_rd_word;
        end
    end

    sram_responder_latency_pipe #(
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stage (w_stage_in),
        .o_stage (w_out)
    );

    assign io_bus.resp       = w_out.payload;
    assign io_bus.resp_valid = w_out.valid;

`ifdef SRAM_RESPONDER_ERR_EN
    logic r_err_seen;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_seen <= 1'b0;
        end else if (w_out.valid && w_out.err) begin
            r_err_seen <= 1'b1;
        end
    end

    assign io_bus.resp_err = w_out.err;
    assign io_bus.err_seen = r_err_seen;
`else
    logic w_unused_err;
    assign w_unused_err = w_out.err;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: three instances (LATENCY 1, 3, 4)
// see the same stimulus and are checked every cycle against a response
// schedule model, plus hand-computed spot checks.
module tb_sram_responder;

    localparam int NS  = 64;
    localparam int ND  = 3;
    localparam int LAT [ND] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_rv;
    logic        tb_wv;
    logic [31:0] tb_adr;
    logic [31:0] tb_data;
    logic [3:0]  tb_strb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        ev [ND][NS];
    logic [31:0] ed [ND][NS];
    logic        ee [ND][NS];
    logic [31:0] mm [2048];

    logic        act_valid [ND];
    logic [31:0] act_resp  [ND];

    always #5 clk = ~clk;

    sram_responder_if if_l1 ();
    sram_responder_if if_l3 ();
    sram_responder_if if_l4 ();

    assign if_l1.r_v = tb_rv;   assign if_l3.r_v = tb_rv;   assign if_l4.r_v = tb_rv;
    assign if_l1.w_v = tb_wv;   assign if_l3.w_v = tb_wv;   assign if_l4.w_v = tb_wv;
    assign if_l1.adr = tb_adr;  assign if_l3.adr = tb_adr;  assign if_l4.adr = tb_adr;
    assign if_l1.data = tb_data; assign if_l3.data = tb_data; assign if_l4.data = tb_data;
    assign if_l1.strobe = tb_strb; assign if_l3.strobe = tb_strb; assign if_l4.strobe = tb_strb;

    assign act_valid[0] = if_l1.resp_valid; assign act_resp[0] = if_l1.resp;
    assign act_valid[1] = if_l3.resp_valid; assign act_resp[1] = if_l3.resp;
    assign act_valid[2] = if_l4.resp_valid; assign act_resp[2] = if_l4.resp;

`ifdef SRAM_RESPONDER_ERR_EN
    logic act_err  [ND];
    logic act_seen [ND];
    logic exp_seen [ND];
    assign act_err[0] = if_l1.resp_err; assign act_seen[0] = if_l1.err_seen;
    assign act_err[1] = if_l3.resp_err; assign act_seen[1] = if_l3.err_seen;
    assign act_err[2] = if_l4.resp_err; assign act_seen[2] = if_l4.err_seen;
`endif

    sram_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .io_bus(if_l1.slave));
    sram_responder #(.LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .io_bus(if_l3.slave));
    sram_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n), .io_bus(if_l4.slave));

    // Model: at each edge, work out the response and book it LAT-1 edges later
    always @(posedge clk) begin
        int          ps;
        int          slot;
        logic        inr;
        logic [32:0] a33;
        int          idx;
        logic [31:0] rdat;
        logic        rerr;
        cyc = cyc + 1;
        ps  = (cyc - 1) % NS;
`ifdef SRAM_RESPONDER_ERR_EN
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) exp_seen[d] = 1'b0;
            else if (ev[d][ps] && ee[d][ps]) exp_seen[d] = 1'b1;
        end
`endif
        for (int d = 0; d < ND; d++) begin
            ev[d][ps] = 1'b0; ed[d][ps] = '0; ee[d][ps] = 1'b0;
        end
        if (!rst_n) begin
            for (int d = 0; d < ND; d++)
                for (int s = 0; s < NS; s++) begin
                    ev[d][s] = 1'b0; ed[d][s] = '0; ee[d][s] = 1'b0;
                end
        end else if (tb_rv || tb_wv) begin
            a33 = {1'b0, tb_adr};
            inr = (a33 >= 33'h2_0000) && (a33 < 33'h2_0000 + 33'd8192);
            idx = int'((tb_adr - 32'h2_0000) >> 2);
            if (tb_wv) begin
                rdat = '0;
                rerr = !inr || (tb_strb == 4'h0);
                if (inr)
                    for (int b = 0; b < 4; b++)
                        if (tb_strb[b]) mm[idx][8*b +: 8] = tb_data[8*b +: 8];
            end else begin
                rdat = inr ? mm[idx] : 32'h0;
                rerr = !inr;
            end
            for (int d = 0; d < ND; d++) begin
                slot = (cyc + LAT[d] - 1) % NS;
                ev[d][slot] = 1'b1; ed[d][slot] = rdat; ee[d][slot] = rerr;
            end
        end
    end

    // Compare every instance against the model on the falling edge
    always @(negedge clk) begin
        int s;
        if (cyc >= 1) begin
            s = cyc % NS;
            for (int d = 0; d < ND; d++) begin
                n_checks++;
                if ((act_valid[d] !== ev[d][s]) || (act_resp[d] !== ed[d][s])) begin
                    n_fail++;
                    $display("FAIL model_L%0d cyc=%0d: got valid=%b resp=%h, expected valid=%b resp=%h",
                             LAT[d], cyc, act_valid[d], act_resp[d], ev[d][s], ed[d][s]);
                end
`ifdef SRAM_RESPONDER_ERR_EN
                n_checks++;
                if ((act_err[d] !== ee[d][s]) || (act_seen[d] !== exp_seen[d])) begin
                    n_fail++;
                    $display("FAIL model_err_L%0d cyc=%0d: got err=%b seen=%b, expected err=%b seen=%b",
                             LAT[d], cyc, act_err[d], act_seen[d], ee[d][s], exp_seen[d]);
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input logic rv, input logic wv, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        tb_rv = rv; tb_wv = wv; tb_adr = a; tb_data = d; tb_strb = s;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            tick();
            set_idle();
        end
    endtask

    initial begin
        logic [31:0] w;
        int unsigned kind;
        logic [31:0] a;
        rst_n = 1'b0;
        set_idle();
        for (int d = 0; d < ND; d++) begin
            for (int s = 0; s < NS; s++) begin
                ev[d][s] = 1'b0; ed[d][s] = '0; ee[d][s] = 1'b0;
            end
`ifdef SRAM_RESPONDER_ERR_EN
            exp_seen[d] = 1'b0;
`endif
        end
        for (int i = 0; i < 2048; i++) begin
            if (i == 0)      w = 32'hDEAD_BEEF;
            else if (i == 1) w = 32'h1122_3344;
            else             w = 32'hA5A5_0000 | 32'(i);
            mm[i] = w;
            u_l1.mem[i] <= w;
            u_l3.mem[i] <= w;
            u_l4.mem[i] <= w;
        end

        // Reset state
        run_to(3);
        chk("reset_valid_l1", 32'(act_valid[0]), 32'h0);
        chk("reset_valid_l4", 32'(act_valid[2]), 32'h0);
        chk("reset_resp_l3", act_resp[1], 32'h0);
        rst_n = 1'b1;

        // Read word 0 accepted at edge 10
        run_to(9);
        set_req(1'b1, 1'b0, 32'h2_0000, 32'h0, 4'h0);
        tick(); set_idle();
        chk("rd0_l1_valid", 32'(act_valid[0]), 32'h1);
        chk("rd0_l1_resp", act_resp[0], 32'hDEAD_BEEF);
        tick();
        chk("rd0_l3_early", 32'(act_valid[1]), 32'h0);
        tick();
        chk("rd0_l3_valid", 32'(act_valid[1]), 32'h1);
        chk("rd0_l3_resp", act_resp[1], 32'hDEAD_BEEF);
        tick();
        chk("rd0_l3_late", 32'(act_valid[1]), 32'h0);
        chk("rd0_l3_idle_resp", act_resp[1], 32'h0);

        // Strobed write then readback
        set_req(1'b0, 1'b1, 32'h2_0004, 32'hAABB_CCDD, 4'b0101);
        tick();
        chk("wr1_ack_valid", 32'(act_valid[0]), 32'h1);
        chk("wr1_ack_resp", act_resp[0], 32'h0);
        set_req(1'b1, 1'b0, 32'h2_0004, 32'h0, 4'h0);
        tick();
        chk("rd1_merged", act_resp[0], 32'h11BB_33DD);

        // Write then immediate read of the same word
        set_req(1'b0, 1'b1, 32'h2_0008, 32'h5, 4'hF);
        tick();
        chk("wr2_ack_resp", act_resp[0], 32'h0);
        set_req(1'b1, 1'b0, 32'h2_0008, 32'h0, 4'h0);
        tick();
        chk("rd2_valid", 32'(act_valid[0]), 32'h1);
        chk("rd2_resp", act_resp[0], 32'h5);

        // Out-of-range reads on both sides of the window
        set_req(1'b1, 1'b0, 32'h1_FFFC, 32'h0, 4'h0);
        tick();
        chk("oor_lo_valid", 32'(act_valid[0]), 32'h1);
        chk("oor_lo_resp", act_resp[0], 32'h0);
`ifdef SRAM_RESPONDER_ERR_EN
        chk("oor_lo_err", 32'(act_err[0]), 32'h1);
`endif
        set_req(1'b1, 1'b0, 32'h2_2000, 32'h0, 4'h0);
        tick();
        chk("oor_hi_resp", act_resp[0], 32'h0);
`ifdef SRAM_RESPONDER_ERR_EN
        chk("oor_hi_err", 32'(act_err[0]), 32'h1);
        chk("oor_seen", 32'(act_seen[0]), 32'h1);
`endif

        // Read and write together is a write
        set_req(1'b1, 1'b1, 32'h2_000C, 32'h7, 4'hF);
        tick();
        chk("rw_ack_resp", act_resp[0], 32'h0);
        set_req(1'b1, 1'b0, 32'h2_000C, 32'h0, 4'h0);
        tick();
        chk("rw_readback", act_resp[0], 32'h7);
        chk("rw_mem3", u_l1.mem[3], 32'h7);

        // Back-to-back reads, reset after the fifth accept
        run_to(30);
        for (int k = 0; k < 8; k++) begin
            if (k >= 5) rst_n = 1'b0;
            set_req(1'b1, 1'b0, 32'h2_0000 + 32'(4 * k), 32'h0, 4'h0);
            tick();
            if (k == 3) chk("burst_l4_w0", act_resp[2], 32'hDEAD_BEEF);
            if (k == 4) chk("burst_l4_w1", act_resp[2], 32'h11BB_33DD);
            if (k >= 5) chk("burst_l4_flushed", 32'(act_valid[2]), 32'h0);
        end
        rst_n = 1'b1;
        set_idle();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_reset_l4_valid", 32'(act_valid[2]), 32'h0);
            chk("post_reset_l4_resp", act_resp[2], 32'h0);
        end
        set_req(1'b1, 1'b0, 32'h2_0004, 32'h0, 4'h0);
        tick();
        chk("post_reset_mem1", act_resp[0], 32'h11BB_33DD);

        // Mixed traffic checked by the model only
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            a = 32'h2_0000 + (32'($urandom_range(0, 15)) << 2);
            if (kind == 9) a = 32'h2_2000 + (32'($urandom_range(0, 3)) << 2);
            set_req(kind < 4 || kind == 9, kind >= 3 && kind < 9, a, $urandom,
                    4'($urandom_range(0, 15)));
            tick();
        end
        set_idle();
        run_to(cyc + 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
